// File: rtl/icache_refill.sv
// ICache line refill engine: one AXI4 INCR burst per miss, beats collected
// into a line buffer, then a single-cycle tag/data/valid write into the RAM.
module icache_refill #(
    parameter int          INDEX_SIZE    = 7,
    parameter int          TAG_SIZE      = 20,
    parameter int          WORD_OFF_SIZE = 3,
    parameter logic [3:0]  AXI_ID        = 4'd0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               miss_req,
    input  logic [31:0]                        miss_addr,
    output logic                               busy,
    output logic                               miss_ack,
    output logic                               refill_err,
    output logic                               ram_wen,
    output logic [INDEX_SIZE-1:0]              ram_a,
    output logic [TAG_SIZE-1:0]                ram_d,
    output logic [32*(2**WORD_OFF_SIZE)-1:0]   ram_dina,
    output logic                               ram_w_valid,
    output logic [3:0]                         arid,
    output logic [31:0]                        araddr,
    output logic [7:0]                         arlen,
    output logic [2:0]                         arsize,
    output logic [1:0]                         arburst,
    output logic                               arvalid,
    input  logic                               arready,
    input  logic [3:0]                         rid,
    input  logic [31:0]                        rdata,
    input  logic [1:0]                         rresp,
    input  logic                               rlast,
    input  logic                               rvalid,
    output logic                               rready
);

    // state | meaning
    // IDLE  | waiting for a miss; miss_req sampled only here
    // AR    | burst address presented, waiting for arready
    // R     | accepting beats into the line buffer
    // WR    | one-cycle RAM write and ack to the requester
    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_WR} state_t;

    localparam int WORDS = 2**WORD_OFF_SIZE;
    localparam int OFF   = WORD_OFF_SIZE + 2;

    state_t                    state_q, state_d;
    logic [TAG_SIZE-1:0]       tag_q, tag_d;
    logic [INDEX_SIZE-1:0]     idx_q, idx_d;
    logic [WORD_OFF_SIZE-1:0]  cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [32*WORDS-1:0]       line_q, line_d;
    logic                      last_word;
    logic                      beat_bad;

    // Byte/word offset of the miss address is irrelevant: the whole line is fetched.
    logic unused_addr_bits;
    assign unused_addr_bits = ^miss_addr[OFF-1:0];

    // State register and refill context; reset drops any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            line_q  <= line_d;
        end
    end

    // Next-state logic: capture miss, AR handshake, beat collection, write-back.
    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        line_d    = line_q;
        last_word = (cnt_q == WORD_OFF_SIZE'(WORDS-1));
        beat_bad  = (rresp != 2'b00) || (rid != AXI_ID) || (rlast != last_word);
        case (state_q)
            S_IDLE: begin
                if (miss_req) begin
                    tag_d   = miss_addr[31 -: TAG_SIZE];
                    idx_d   = miss_addr[OFF +: INDEX_SIZE];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (arready) state_d = S_R;
            end
            S_R: begin
                if (rvalid) begin
                    line_d[32*cnt_q +: 32] = rdata;
                    err_d = err_q | beat_bad;
                    // An early rlast ends the burst; the counter never wraps.
                    if (last_word || rlast) state_d = S_WR;
                    else                    cnt_d   = cnt_q + WORD_OFF_SIZE'(1);
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign arvalid     = (state_q == S_AR);
    assign rready      = (state_q == S_R);
    assign ram_wen     = (state_q == S_WR);
    assign miss_ack    = (state_q == S_WR);
    assign refill_err  = (state_q == S_WR) && err_q;
    // A failed line is still written, but marked invalid.
    assign ram_w_valid = (state_q == S_WR) && !err_q;
    assign ram_a       = idx_q;
    assign ram_d       = tag_q;
    assign ram_dina    = line_q;
    assign araddr      = {tag_q, idx_q, {OFF{1'b0}}};
    assign arid        = AXI_ID;
    assign arlen       = 8'(WORDS-1);
    assign arsize      = 3'b010;
    assign arburst     = 2'b01;

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;

    logic         clk = 1'b0;
    logic         reset, miss_req;
    logic [31:0]  miss_addr;
    logic         busy, miss_ack, refill_err, ram_wen, ram_w_valid;
    logic [6:0]   ram_a;
    logic [19:0]  ram_d;
    logic [255:0] ram_dina;
    logic [3:0]   arid, rid;
    logic [31:0]  araddr, rdata;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst, rresp;
    logic         arvalid, arready, rlast, rvalid, rready;

    icache_refill dut (
        .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
        .busy(busy), .miss_ack(miss_ack), .refill_err(refill_err),
        .ram_wen(ram_wen), .ram_a(ram_a), .ram_d(ram_d), .ram_dina(ram_dina),
        .ram_w_valid(ram_w_valid), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Burst plan offered by the slave, beat by beat.
    logic [31:0] p_data [8];
    logic [1:0]  p_resp [8];
    logic [3:0]  p_id   [8];
    logic        p_last [8];

    // Reference model: RAM line image and expected outcome.
    logic [31:0] exp_line [8];
    int          exp_k;
    logic        exp_err;

    // Observations from the driver.
    int           t, b, wr_t, last_beat_t, ar_cycles, ar_hs, ar_first_t, rready_after;
    bit           wr_seen, ar_stable, aborted, ack_ok, done_beats;
    logic [31:0]  ar_addr0;
    logic [6:0]   o_a;
    logic [19:0]  o_d;
    logic [255:0] o_dina;
    logic         o_valid, o_err, o_ack, post_busy;

    function automatic logic [255:0] exp_dina();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = exp_line[i];
        return v;
    endfunction

    task automatic plan_clean();
        for (int i = 0; i < 8; i++) begin
            p_data[i] = $urandom;
            p_resp[i] = 2'b00;
            p_id[i]   = 4'd0;
            p_last[i] = (i == 7);
        end
    endtask

    // The line ends at the first rlast or after 8 beats; any bad beat taints it.
    task automatic model_refill();
        exp_k = 8;
        for (int i = 7; i >= 0; i--) if (p_last[i]) exp_k = i + 1;
        exp_err = 1'b0;
        for (int i = 0; i < exp_k; i++) begin
            exp_line[i] = p_data[i];
            if (p_resp[i] != 2'b00 || p_id[i] != 4'd0 || p_last[i] != (i == 7))
                exp_err = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_line[i] = 32'h0;
    endtask

    task automatic run_refill(input logic [31:0] addr, input int ar_delay, input int gap_pct,
                              input int abort_beat, input bit hold_req);
        int ard = ar_delay;
        wr_seen = 0; ar_stable = 1; aborted = 0; ack_ok = 1; done_beats = 0;
        ar_cycles = 0; ar_hs = 0; ar_first_t = -1; rready_after = 0;
        wr_t = -1; last_beat_t = -100; b = 0; t = 0; post_busy = 1'bx;
        miss_req = 1'b1; miss_addr = addr; rvalid = 1'b0; arready = 1'b0;
        while (t < 300) begin
            @(posedge clk); #1; t++;
            if (!hold_req) miss_req = 1'b0;
            if (ram_wen !== miss_ack) ack_ok = 0;
            if (wr_seen) begin
                post_busy = busy;
                break;
            end
            if (ram_wen) begin
                wr_seen = 1; wr_t = t;
                o_a = ram_a; o_d = ram_d; o_dina = ram_dina;
                o_valid = ram_w_valid; o_err = refill_err; o_ack = miss_ack;
            end
            arready = 1'b0;
            if (arvalid) begin
                ar_cycles++;
                if (ar_first_t < 0) begin ar_first_t = t; ar_addr0 = araddr; end
                else if (araddr !== ar_addr0) ar_stable = 0;
                if (ard > 0) ard--;
                else begin arready = 1'b1; ar_hs++; end
            end
            rvalid = 1'b0;
            if (rready) begin
                if (done_beats) rready_after++;
                else if ($urandom_range(99) >= gap_pct) begin
                    rvalid = 1'b1; rdata = p_data[b]; rresp = p_resp[b];
                    rid = p_id[b]; rlast = p_last[b];
                    if (b == abort_beat) begin reset = 1'b1; aborted = 1; end
                    last_beat_t = t;
                    if (p_last[b] || b == 7) done_beats = 1;
                    b++;
                end
            end
            if (aborted) begin
                @(posedge clk); #1;
                reset = 1'b0; rvalid = 1'b0; miss_req = 1'b0;
                break;
            end
        end
        rvalid = 1'b0; arready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, arvalid, rready, ram_wen, miss_ack, refill_err, ram_w_valid} !== 7'b0)
            $display("FAIL reset_ctrl got %b want 0",
                     {busy, arvalid, rready, ram_wen, miss_ack, refill_err, ram_w_valid});
        else n_pass++;
        n_checks++;
        if ({araddr, ram_a, ram_d} !== 59'b0 || ram_dina !== 256'b0)
            $display("FAIL reset_data araddr=%h ram_a=%h ram_d=%h", araddr, ram_a, ram_d);
        else n_pass++;
        n_checks++;
        if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd7, 3'b010, 2'b01})
            $display("FAIL reset_const got %h want %h", {arid, arlen, arsize, arburst},
                     {4'd0, 8'd7, 3'b010, 2'b01});
        else n_pass++;
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        plan_clean();
        for (int i = 0; i < 8; i++) p_data[i] = 32'hA0 + i;
        model_refill();
        run_refill(32'h1FC0_0124, 0, 0, -1, 0);
        n_checks++;
        if (ar_addr0 !== 32'h1FC0_0120) $display("FAIL basic_araddr got %h want 1fc00120", ar_addr0);
        else n_pass++;
        n_checks++;
        if (!wr_seen || wr_t != 10) $display("FAIL basic_latency got %0d want 10", wr_t);
        else n_pass++;
        n_checks++;
        if (o_a !== 7'h09 || o_d !== 20'h1FC00)
            $display("FAIL basic_ram_addr got a=%h d=%h want a=09 d=1fc00", o_a, o_d);
        else n_pass++;
        n_checks++;
        if (o_dina !== exp_dina()) $display("FAIL basic_line got %h want %h", o_dina, exp_dina());
        else n_pass++;
        n_checks++;
        if ({o_ack, o_valid, o_err} !== 3'b110 || !ack_ok)
            $display("FAIL basic_flags got ack/valid/err=%b want 110", {o_ack, o_valid, o_err});
        else n_pass++;
        n_checks++;
        if (post_busy !== 1'b0) $display("FAIL basic_idle_after got busy=%b want 0", post_busy);
        else n_pass++;
    endtask

    task automatic test_ar_stall();
        plan_clean();
        model_refill();
        run_refill(32'hDEAD_BEEF, 3, 0, -1, 0);
        n_checks++;
        if (ar_cycles != 4 || ar_hs != 1 || !ar_stable)
            $display("FAIL ar_stall got cycles=%0d hs=%0d stable=%0d want 4 1 1",
                     ar_cycles, ar_hs, ar_stable);
        else n_pass++;
        n_checks++;
        if (ar_addr0 !== 32'hDEAD_BEE0) $display("FAIL ar_stall_addr got %h want deadbee0", ar_addr0);
        else n_pass++;
        n_checks++;
        if (!wr_seen || o_dina !== exp_dina() || wr_t != 13)
            $display("FAIL ar_stall_line got wr_t=%0d line=%h want 13 %h", wr_t, o_dina, exp_dina());
        else n_pass++;
    endtask

    task automatic test_r_gaps();
        plan_clean();
        model_refill();
        run_refill($urandom, 0, 50, -1, 0);
        n_checks++;
        if (b != 8 || !wr_seen || o_dina !== exp_dina())
            $display("FAIL r_gaps_line got beats=%0d line=%h want 8 %h", b, o_dina, exp_dina());
        else n_pass++;
        n_checks++;
        if (wr_t != last_beat_t + 1) $display("FAIL r_gaps_timing got %0d want %0d", wr_t, last_beat_t + 1);
        else n_pass++;
    endtask

    task automatic test_bad_resp();
        plan_clean();
        p_resp[5] = 2'b10;
        model_refill();
        run_refill($urandom, 0, 20, -1, 0);
        n_checks++;
        if (!wr_seen || {o_ack, o_err, o_valid} !== 3'b110)
            $display("FAIL bad_resp got ack/err/valid=%b want 110", {o_ack, o_err, o_valid});
        else n_pass++;
        n_checks++;
        if (o_dina !== exp_dina()) $display("FAIL bad_resp_line got %h want %h", o_dina, exp_dina());
        else n_pass++;
    endtask

    task automatic test_early_rlast();
        plan_clean();
        p_last[7] = 1'b0;
        p_last[2] = 1'b1;
        model_refill();
        run_refill($urandom, 1, 0, -1, 0);
        n_checks++;
        if (b != 3 || wr_t != last_beat_t + 1 || rready_after != 0)
            $display("FAIL early_rlast got beats=%0d wr_t=%0d extra_rready=%0d want 3 %0d 0",
                     b, wr_t, rready_after, last_beat_t + 1);
        else n_pass++;
        n_checks++;
        if ({o_err, o_valid} !== 2'b10 || o_dina !== exp_dina())
            $display("FAIL early_rlast_line got err/valid=%b line=%h want 10 %h",
                     {o_err, o_valid}, o_dina, exp_dina());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        plan_clean();
        run_refill($urandom, 0, 0, 4, 0);
        model_reset();
        n_checks++;
        if (!aborted || {busy, arvalid, rready, ram_wen, miss_ack, refill_err, ram_w_valid} !== 7'b0 ||
            {araddr, ram_a, ram_d} !== 59'b0 || ram_dina !== 256'b0)
            $display("FAIL reset_mid_outputs got ctrl=%b araddr=%h dina=%h want 0",
                     {busy, arvalid, rready, ram_wen, miss_ack, refill_err, ram_w_valid},
                     araddr, ram_dina);
        else n_pass++;
        plan_clean();
        model_refill();
        run_refill(32'h8000_0040, 0, 0, -1, 0);
        n_checks++;
        if (!wr_seen || wr_t != 10 || o_dina !== exp_dina() || {o_err, o_valid} !== 2'b01)
            $display("FAIL reset_mid_recover got wr_t=%0d err/valid=%b line=%h want 10 01 %h",
                     wr_t, {o_err, o_valid}, o_dina, exp_dina());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [31:0] addr;
            int mode;
            addr = $urandom;
            mode = $urandom_range(0, 5);
            plan_clean();
            case (mode)
                0: p_resp[$urandom_range(0, 7)] = 2'($urandom_range(1, 3));
                1: p_id[$urandom_range(0, 7)] = 4'($urandom_range(1, 15));
                2: begin p_last[7] = 1'b0; p_last[$urandom_range(0, 6)] = 1'b1; end
                3: p_last[7] = 1'b0;
                default: ;
            endcase
            model_refill();
            run_refill(addr, $urandom_range(0, 3), 30, -1, 0);
            n_checks++;
            if (!wr_seen || o_a !== addr[11:5] || o_d !== addr[31:12] || ar_addr0 !== {addr[31:5], 5'b0})
                $display("FAIL random_addr[%0d] got a=%h d=%h ar=%h for addr %h", n, o_a, o_d, ar_addr0, addr);
            else n_pass++;
            n_checks++;
            if (o_dina !== exp_dina() || o_err !== exp_err || o_valid !== !exp_err || b != exp_k)
                $display("FAIL random_line[%0d] got err=%b beats=%0d line=%h want err=%b beats=%0d line=%h",
                         n, o_err, b, o_dina, exp_err, exp_k, exp_dina());
            else n_pass++;
            n_checks++;
            if (wr_t != last_beat_t + 1 || rready_after != 0 || !ack_ok || ar_hs != 1)
                $display("FAIL random_timing[%0d] got wr_t=%0d extra=%0d hs=%0d want %0d 0 1",
                         n, wr_t, rready_after, ar_hs, last_beat_t + 1);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        plan_clean();
        model_refill();
        run_refill(32'h0000_1000, 0, 0, -1, 1);
        @(posedge clk); #1;
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h0000_1000)
            $display("FAIL back_to_back got arvalid=%b araddr=%h want 1 00001000", arvalid, araddr);
        else n_pass++;
        miss_req = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL back_to_back_idle got busy=%b want 0", busy);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; miss_req = 1'b0; miss_addr = '0; arready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        test_reset();
        test_basic();
        test_ar_stall();
        test_r_gaps();
        test_bad_resp();
        test_early_rlast();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
